// File: rtl/noise_reg_if_if.sv
// Register bus for the noise channel register file: write/read strobes, address, data, read response.
interface noise_reg_if_if;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 8;

  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  modport master (
    output wr_en, rd_en, addr, wdata,
    input  rdata, rvalid
  );

  modport slave (
    input  wr_en, rd_en, addr, wdata,
    output rdata, rvalid
  );
endinterface

// File: rtl/noise_reg_if.sv
// NR41-NR44 register file for the noise channel: field decode, length-load/trigger pulses,
// channel-active flag and masked register read-back.
module noise_reg_if (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 apu_enable,
  noise_reg_if_if.slave        bus,
  input  logic                 len_expired,
  output logic [5:0]           length,
  output logic                 len_load,
  output logic [3:0]           env_init,
  output logic                 env_dir,
  output logic [2:0]           env_period,
  output logic [3:0]           clk_shift,
  output logic                 width_mode,
  output logic [2:0]           divisor,
  output logic                 len_enable,
  output logic                 trigger,
  output logic                 chan_on
);
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 6;

  localparam logic [ADDR_W-1:0] ADDR_NR41 = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_NR42 = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_NR43 = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_NR44 = ADDR_W'(3);

  logic [LEN_W-1:0]  nr41_q;
  logic [DATA_W-1:0] nr42_q;
  logic [DATA_W-1:0] nr43_q;
  logic              nr44_len_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              len_load_q;
  logic              trigger_q;
  logic              chan_on_q;

  logic              wr_nr41_c;
  logic              wr_nr42_c;
  logic              wr_nr43_c;
  logic              wr_nr44_c;
  logic              trig_set_c;
  logic              dac_on_c;
  logic              chan_on_d_c;
  logic [DATA_W-1:0] rd_val_c;

  // Write decode, DAC state seen through a same-edge NR42 write, and channel-active next value.
  always_comb begin
    wr_nr41_c   = 1'b0;
    wr_nr42_c   = 1'b0;
    wr_nr43_c   = 1'b0;
    wr_nr44_c   = 1'b0;
    if (bus.wr_en && apu_enable) begin
      wr_nr41_c = (bus.addr == ADDR_NR41);
      wr_nr42_c = (bus.addr == ADDR_NR42);
      wr_nr43_c = (bus.addr == ADDR_NR43);
      wr_nr44_c = (bus.addr == ADDR_NR44);
    end
    trig_set_c  = wr_nr44_c && bus.wdata[7];
    dac_on_c    = wr_nr42_c ? (|bus.wdata[7:3]) : (|nr42_q[7:3]);
    chan_on_d_c = chan_on_q;
    if (trig_set_c) begin
      chan_on_d_c = dac_on_c;
    end else if (len_expired || (wr_nr42_c && !dac_on_c)) begin
      chan_on_d_c = 1'b0;
    end
  end

  // Masked read-back of pre-write contents; a powered-down APU reads as cleared registers.
  always_comb begin
    rd_val_c = DATA_W'(8'hFF);
    case (bus.addr)
      ADDR_NR41: rd_val_c = DATA_W'(8'hFF);
      ADDR_NR42: rd_val_c = apu_enable ? nr42_q : '0;
      ADDR_NR43: rd_val_c = apu_enable ? nr43_q : '0;
      ADDR_NR44: rd_val_c = {1'b1, apu_enable & nr44_len_q, 6'b111111};
      default:   rd_val_c = DATA_W'(8'hFF);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nr41_q     <= '0;
      nr42_q     <= '0;
      nr43_q     <= '0;
      nr44_len_q <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      len_load_q <= 1'b0;
      trigger_q  <= 1'b0;
      chan_on_q  <= 1'b0;
    end else begin
      rvalid_q <= bus.rd_en;
      if (bus.rd_en) begin
        rdata_q <= rd_val_c;
      end
      if (!apu_enable) begin
        nr41_q     <= '0;
        nr42_q     <= '0;
        nr43_q     <= '0;
        nr44_len_q <= 1'b0;
        len_load_q <= 1'b0;
        trigger_q  <= 1'b0;
        chan_on_q  <= 1'b0;
      end else begin
        if (wr_nr41_c) nr41_q     <= bus.wdata[LEN_W-1:0];
        if (wr_nr42_c) nr42_q     <= bus.wdata;
        if (wr_nr43_c) nr43_q     <= bus.wdata;
        if (wr_nr44_c) nr44_len_q <= bus.wdata[6];
        len_load_q <= wr_nr41_c;
        trigger_q  <= trig_set_c;
        chan_on_q  <= chan_on_d_c;
      end
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign length     = nr41_q;
  assign len_load   = len_load_q;
  assign env_init   = nr42_q[7:4];
  assign env_dir    = nr42_q[3];
  assign env_period = nr42_q[2:0];
  assign clk_shift  = nr43_q[7:4];
  assign width_mode = nr43_q[3];
  assign divisor    = nr43_q[2:0];
  assign len_enable = nr44_len_q;
  assign trigger    = trigger_q;
  assign chan_on    = chan_on_q;
endmodule

// File: tb/tb_noise_reg_if.sv
// Scoreboard bench for noise_reg_if: a per-cycle register-file model predicts every output,
// a monitor compares after each rising edge.
module tb_noise_reg_if;
  typedef struct packed {
    logic [7:0] rdata;
    logic       rvalid;
    logic [5:0] length;
    logic       len_load;
    logic [3:0] env_init;
    logic       env_dir;
    logic [2:0] env_period;
    logic [3:0] clk_shift;
    logic       width_mode;
    logic [2:0] divisor;
    logic       len_enable;
    logic       trigger;
    logic       chan_on;
  } outs_t;

  logic       clk;
  logic       reset;
  logic       apu_enable;
  logic       len_expired;
  logic [5:0] length;
  logic       len_load;
  logic [3:0] env_init;
  logic       env_dir;
  logic [2:0] env_period;
  logic [3:0] clk_shift;
  logic       width_mode;
  logic [2:0] divisor;
  logic       len_enable;
  logic       trigger;
  logic       chan_on;

  noise_reg_if_if bus ();

  noise_reg_if dut (
    .clk         (clk),
    .reset       (reset),
    .apu_enable  (apu_enable),
    .bus         (bus),
    .len_expired (len_expired),
    .length      (length),
    .len_load    (len_load),
    .env_init    (env_init),
    .env_dir     (env_dir),
    .env_period  (env_period),
    .clk_shift   (clk_shift),
    .width_mode  (width_mode),
    .divisor     (divisor),
    .len_enable  (len_enable),
    .trigger     (trigger),
    .chan_on     (chan_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  outs_t exp_q[$];

  // Reference state: register bytes as stored, plus pulse/flag/read state.
  logic [7:0] m_reg [4];
  logic [7:0] m_rdata;
  logic       m_rvalid;
  logic       m_trig;
  logic       m_lenld;
  logic       m_chan;

  function automatic logic [7:0] read_val(input logic [1:0] a, input logic [7:0] r1,
                                          input logic [7:0] r2, input logic [7:0] r3);
    case (a)
      2'd0:    return 8'hFF;
      2'd1:    return r1;
      2'd2:    return r2;
      default: return 8'hBF | (r3 & 8'h40);
    endcase
  endfunction

  function automatic outs_t model_outs();
    outs_t o;
    o.rdata      = m_rdata;
    o.rvalid     = m_rvalid;
    o.length     = m_reg[0][5:0];
    o.len_load   = m_lenld;
    o.env_init   = m_reg[1][7:4];
    o.env_dir    = m_reg[1][3];
    o.env_period = m_reg[1][2:0];
    o.clk_shift  = m_reg[2][7:4];
    o.width_mode = m_reg[2][3];
    o.divisor    = m_reg[2][2:0];
    o.len_enable = m_reg[3][6];
    o.trigger    = m_trig;
    o.chan_on    = m_chan;
    return o;
  endfunction

  // Drive one cycle of stimulus and push the outputs expected after the next rising edge.
  task automatic drive(input logic rst, input logic en, input logic wr, input logic rd,
                       input logic [1:0] a, input logic [7:0] d, input logic lexp);
    logic dac;
    @(negedge clk);
    reset = rst; apu_enable = en; bus.wr_en = wr; bus.rd_en = rd;
    bus.addr = a; bus.wdata = d; len_expired = lexp;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
      m_rdata = 8'h00; m_rvalid = 1'b0; m_trig = 1'b0; m_lenld = 1'b0; m_chan = 1'b0;
    end else begin
      m_rvalid = rd;
      if (rd) m_rdata = en ? read_val(a, m_reg[1], m_reg[2], m_reg[3]) : read_val(a, 8'h00, 8'h00, 8'h00);
      if (!en) begin
        for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
        m_trig = 1'b0; m_lenld = 1'b0; m_chan = 1'b0;
      end else begin
        m_lenld = wr && (a == 2'd0);
        m_trig  = wr && (a == 2'd3) && d[7];
        if (wr) begin
          case (a)
            2'd0:    m_reg[0] = d & 8'h3F;
            2'd1:    m_reg[1] = d;
            2'd2:    m_reg[2] = d;
            default: m_reg[3] = d & 8'h40;
          endcase
        end
        dac = (m_reg[1][7:3] != 5'd0);
        if (m_trig)                                   m_chan = dac;
        else if (lexp || (wr && a == 2'd1 && !dac))   m_chan = 1'b0;
      end
    end
    exp_q.push_back(model_outs());
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    drive(1'b0, 1'b1, 1'b1, 1'b0, a, d, 1'b0);
  endtask

  task automatic rd_reg(input logic [1:0] a);
    drive(1'b0, 1'b1, 1'b0, 1'b1, a, 8'h00, 1'b0);
  endtask

  task automatic idle(input logic en);
    drive(1'b0, en, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
  endtask

  // Monitor: compare every output after each rising edge that has a pending expectation.
  initial begin
    outs_t e;
    outs_t act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        act = '{bus.rdata, bus.rvalid, length, len_load, env_init, env_dir, env_period,
                clk_shift, width_mode, divisor, len_enable, trigger, chan_on};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL outputs t=%0t: got rdata=%h rv=%b len=%0d ll=%b env=%h/%b/%0d nr43=%h/%b/%0d le=%b trig=%b on=%b, expected rdata=%h rv=%b len=%0d ll=%b env=%h/%b/%0d nr43=%h/%b/%0d le=%b trig=%b on=%b",
                   $time, act.rdata, act.rvalid, act.length, act.len_load, act.env_init, act.env_dir,
                   act.env_period, act.clk_shift, act.width_mode, act.divisor, act.len_enable,
                   act.trigger, act.chan_on, e.rdata, e.rvalid, e.length, e.len_load, e.env_init,
                   e.env_dir, e.env_period, e.clk_shift, e.width_mode, e.divisor, e.len_enable,
                   e.trigger, e.chan_on);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; apu_enable = 1'b1; len_expired = 1'b0;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = 2'd0; bus.wdata = 8'h00;

    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 8'h80, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    idle(1'b1);

    // Trigger with DAC on, then with DAC off and length enable set
    wr_reg(2'd1, 8'hF0); wr_reg(2'd3, 8'h80); idle(1'b1); idle(1'b1);
    wr_reg(2'd1, 8'h00); wr_reg(2'd3, 8'hC0); rd_reg(2'd3); idle(1'b1);

    // Length expiry clears; trigger on the same edge as expiry wins
    wr_reg(2'd1, 8'hF0); wr_reg(2'd3, 8'h80); idle(1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1); idle(1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 8'h80, 1'b1); idle(1'b1);
    wr_reg(2'd3, 8'h80); wr_reg(2'd3, 8'h80); idle(1'b1);

    // Length load and NR43 fields
    wr_reg(2'd0, 8'hFF); rd_reg(2'd0); wr_reg(2'd2, 8'h5B); rd_reg(2'd2); idle(1'b1);

    // DAC-off write clears chan_on; power-down clears and blocks writes
    wr_reg(2'd3, 8'h80); wr_reg(2'd1, 8'h07); idle(1'b1);
    wr_reg(2'd1, 8'hF8); wr_reg(2'd3, 8'hC0);
    idle(1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 8'h12, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 8'h00, 1'b0);
    idle(1'b1);

    // Same-cycle read and write of one register returns the old value
    wr_reg(2'd2, 8'hA5);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 8'h3C, 1'b0);
    rd_reg(2'd2); idle(1'b1);

    // Reset in the cycle after a triggering write
    wr_reg(2'd1, 8'hF0); wr_reg(2'd3, 8'h80);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 8'hC0, 1'b1);
    idle(1'b1); rd_reg(2'd3);

    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(63) == 0), ($urandom_range(15) != 0), 1'($urandom_range(1)),
            1'($urandom_range(1)), 2'($urandom_range(3)), 8'($urandom), ($urandom_range(7) == 0));
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/noise_reg_if.md
NOISE_REG_IF -- requirements
Module: noise_reg_if

Interface
REQ-001 SHALL: clk  input  1  system clock (4.194304 MHz base clock); all state updates on rising edge.
REQ-002 SHALL: reset  input  1  synchronous, active-high; sampled on rising clk edge only.
REQ-003 SHALL: apu_enable  input  1  master sound power; low = register file held cleared, writes ignored.
REQ-004 SHALL: wr_en  input  1  single-cycle write strobe.
REQ-005 SHALL: rd_en  input  1  single-cycle read strobe.
REQ-006 SHALL: addr  input  2  register select: 0=NR41, 1=NR42, 2=NR43, 3=NR44.
REQ-007 SHALL: wdata  input  8  write data.
REQ-008 SHALL: rdata  output  8  registered read data.
REQ-009 SHALL: rvalid  output  1  high for one cycle when rdata is valid.
REQ-010 SHALL: length  output  6  NR41[5:0] length load value to noise channel.
REQ-011 SHALL: len_load  output  1  one-cycle pulse, NR41 written.
REQ-012 SHALL: env_init / env_dir / env_period  output  4/1/3  NR42[7:4] / NR42[3] / NR42[2:0].
REQ-013 SHALL: clk_shift / width_mode / divisor  output  4/1/3  NR43[7:4] / NR43[3] / NR43[2:0].
REQ-014 SHALL: len_enable  output  1  NR44[6].
REQ-015 SHALL: trigger  output  1  one-cycle restart pulse to noise channel.
REQ-016 SHALL: len_expired  input  1  pulse from noise channel, length counter reached zero.
REQ-017 SHALL: chan_on  output  1  channel-active status flag.

Function
REQ-018 SHALL: write with wr_en=1 and apu_enable=1 captures wdata into addressed register at that edge; field outputs reflect new value from the following cycle.
REQ-019 SHALL: NR41 stores only wdata[5:0]; wdata[7:6] discarded; NR44 stores only bit 6; bit 7 not stored.
REQ-020 SHALL: len_load high exactly the one cycle after any accepted NR41 write; never otherwise.
REQ-021 SHALL: trigger high exactly the one cycle after an accepted NR44 write with wdata[7]=1; NR44 write with wdata[7]=0 gives no pulse; back-to-back triggering writes give back-to-back pulses.
REQ-022 SHALL: DAC-enabled defined as NR42[7:3] != 0, evaluated on register contents including a same-edge NR42 write.
REQ-023 SHALL: chan_on set at the edge that asserts trigger if DAC enabled; stays 0 if DAC disabled (trigger still pulses).
REQ-024 SHALL: chan_on cleared at the edge following len_expired=1, or following an accepted NR42 write leaving DAC disabled.
REQ-025 SHALL: trigger-setting and len_expired on same edge -> chan_on = 1 (trigger wins); trigger with DAC disabled -> 0.
REQ-026 SHALL: read: rd_en=1 -> rdata/rvalid valid the next cycle; rvalid low otherwise; rdata holds last value when rvalid low.
REQ-027 SHALL: read masks: NR41 reads 0xFF; NR42 reads stored 8 bits; NR43 reads stored 8 bits; NR44 reads {1, NR44[6], 6'b111111}.
REQ-028 SHALL: rd_en and wr_en same cycle, same addr -> rdata returns pre-write value; write still takes effect.
REQ-029 SHALL: apu_enable=0 -> at each edge all registers, chan_on, trigger, len_load cleared; writes ignored; reads still serviced with masks applied to cleared contents (NR41 0xFF, NR44 0xBF).

Reset
REQ-030 SHALL: reset=1 at edge -> all stored registers 0, all field outputs 0, trigger=0, len_load=0, chan_on=0, rdata=0x00, rvalid=0; reset has priority over apu_enable, wr_en, rd_en, len_expired.
REQ-031 SHALL: reset asserted between NR44 write and trigger cycle cancels the pulse (trigger=0 following cycle).

Verification
REQ-032 SHALL: write NR42=0xF0, then NR44=0x80 -> trigger high 1 cycle, chan_on=1 same cycle, env_init=15, len_enable=0.
REQ-033 SHALL: write NR42=0x00, NR44=0xC0 -> trigger pulses, chan_on stays 0, len_enable=1; read NR44 -> rdata=0xFF, rvalid 1 cycle.
REQ-034 SHALL: chan_on=1, pulse len_expired -> chan_on=0 next cycle; repeat with NR44=0x80 written same cycle as len_expired -> chan_on=1.
REQ-035 SHALL: write NR41=0xFF -> length=63, len_load 1 cycle; read NR41 -> 0xFF; write NR43=0x5B -> clk_shift=5, width_mode=1, divisor=3, read back 0x5B.
REQ-036 SHALL: chan_on=1, write NR42=0x07 -> chan_on=0 next cycle; drop apu_enable -> all fields 0, write NR43=0x12 ignored, read NR43 -> 0x00.
REQ-037 SHALL: assert reset mid-sequence (cycle after NR44=0x80 write) -> trigger=0, chan_on=0, all outputs at REQ-030 values.
